circ_mtx_vec_mul_m31: RTL and testbench

Fully pipelined circulant matrix × vector multiplier over the Mersenne-31 prime field (p = 2^31 − 1). The N×N circulant matrix is given by its first row. The block forms all N dot products in parallel with a fixed latency. It implements the linear diffusion (concrete) layer of the Monolith permutation and takes one new input vector per clock.

---
 rtl/circ_mtx_vec_mul_m31_if.sv | 15 +
 rtl/circ_mtx_vec_mul_m31.sv | 109 ++++++++++
 tb/tb_circ_mtx_vec_mul_m31.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/circ_mtx_vec_mul_m31_if.sv
// Bus bundle for the circulant matrix-vector multiplier.
// The master drives the matrix first row and the vector.
// The slave returns the product vector and the valid flag.
interface circ_mtx_vec_mul_m31_if #(
    parameter int WORD_WIDTH = 31,
    parameter int STATE_SIZE = 16
);
    logic [0:STATE_SIZE-1][WORD_WIDTH-1:0] mtx_row;
    logic [0:STATE_SIZE-1][WORD_WIDTH-1:0] vec;
    logic [0:STATE_SIZE-1][WORD_WIDTH-1:0] result;
    logic                                  valid;

    modport master (output mtx_row, output vec, input result, input valid);
    modport slave  (input mtx_row, input vec, output result, output valid);
endinterface

// File: rtl/circ_mtx_vec_mul_m31.sv
// Circulant matrix x vector multiplier over GF(2^31 - 1).
// Three register stages:
//   1. N*N reduced products
//   2. folded row sums
//   3. canonical result
// Free-running, one vector per clock, fixed latency of 3.
module circ_mtx_vec_mul_m31 #(
    parameter int WORD_WIDTH = 31,
    parameter int STATE_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    circ_mtx_vec_mul_m31_if.slave   bus
);
    localparam int W     = WORD_WIDTH;
    localparam int N     = STATE_SIZE;
    localparam int PW    = 2 * W;
    // Row sums of N canonical words, plus one spare bit.
    localparam int SUM_W = W + $clog2(N) + 1;
    localparam logic [W:0] P_EXT = {1'b0, {W{1'b1}}};

    typedef logic [0:N-1][W-1:0] word_vec_t;

    // Maps a value in [0, 2p) onto [0, p-1].
    function automatic logic [W-1:0] canon(input logic [W:0] x);
        logic [W:0] y;
        y = (x >= P_EXT) ? (x - P_EXT) : x;
        return y[W-1:0];
    endfunction

    // Full product followed by two folds.
    // The second fold leaves at most p+1, so one subtract is enough.
    // A non-canonical input of p behaves as 0.
    function automatic logic [W-1:0] mul_mod(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [PW-1:0] x;
        logic [W:0]    f1;
        logic [W:0]    f2;
        x  = PW'(a) * PW'(b);
        f1 = {1'b0, x[W-1:0]} + {1'b0, x[PW-1:W]};
        f2 = {1'b0, f1[W-1:0]} + {{W{1'b0}}, f1[W]};
        return canon(f2);
    endfunction

    // Sums one row of reduced products and folds the sum once.
    // The result is at most p + (N - 1), which fits in W+1 bits.
    function automatic logic [W:0] row_fold(input word_vec_t row);
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int j = 0; j < N; j++) begin
            acc = acc + SUM_W'(row[j]);
        end
        return {1'b0, acc[W-1:0]} + (W+1)'(acc[SUM_W-1:W]);
    endfunction

    word_vec_t [0:N-1]          prod_d, prod_q;
    logic [0:N-1][W:0]          sum_d,  sum_q;
    word_vec_t                  res_d,  res_q;
    logic [2:0]                 vld_pipe_d, vld_pipe_q;

    // Stage 1: row i uses the first row rotated right by i.
    always_comb begin
        prod_d = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod_d[i][j] = mul_mod(bus.mtx_row[(j - i + N) % N], bus.vec[j]);
            end
        end
    end

    // Stage 2: sum each row of registered products and fold once.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N; i++) begin
            sum_d[i] = row_fold(prod_q[i]);
        end
    end

    // Stage 3: final fold and canonical subtract.
    always_comb begin
        res_d = '0;
        for (int i = 0; i < N; i++) begin
            res_d[i] = canon({1'b0, sum_q[i][W-1:0]} + (W+1)'(sum_q[i][W]));
        end
    end

    // Valid shift register: fills with ones once reset is released.
    always_comb begin
        vld_pipe_d = {vld_pipe_q[1:0], 1'b1};
    end

    // Pipeline registers. Reset clears every stage and takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q     <= '0;
            sum_q      <= '0;
            res_q      <= '0;
            vld_pipe_q <= '0;
        end else begin
            prod_q     <= prod_d;
            sum_q      <= sum_d;
            res_q      <= res_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign bus.result = res_q;
    assign bus.valid  = vld_pipe_q[2];
endmodule

// File: tb/tb_circ_mtx_vec_mul_m31.sv
// Directed table vectors, a reset/refill sequence and a random stream
// for circ_mtx_vec_mul_m31. The stream uses a plain % reference model.
module tb_circ_mtx_vec_mul_m31;
    localparam int W   = 31;
    localparam int N   = 16;
    localparam logic [W-1:0] P = 31'h7FFFFFFF;
    localparam int NTBL   = 10;
    localparam int NSTRM  = 300;
    localparam int RST_T  = 150;

    typedef logic [0:N-1][W-1:0] rvec_t;
    typedef struct {
        rvec_t c;
        rvec_t v;
        rvec_t r;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nmis = 0;

    circ_mtx_vec_mul_m31_if #(.WORD_WIDTH(W), .STATE_SIZE(N)) bus ();

    circ_mtx_vec_mul_m31 #(.WORD_WIDTH(W), .STATE_SIZE(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic rvec_t ref_mul(input rvec_t c, input rvec_t v);
        rvec_t r;
        longint unsigned p64;
        longint unsigned acc;
        p64 = 64'(P);
        r = '0;
        for (int i = 0; i < N; i++) begin
            acc = 0;
            for (int j = 0; j < N; j++) begin
                acc = (acc + (64'(c[(j - i + N) % N]) % p64) * (64'(v[j]) % p64)) % p64;
            end
            r[i] = W'(acc);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] x;
        case ($urandom_range(0, 7))
            0:       x = P;
            1:       x = P - 1;
            default: x = W'($urandom());
        endcase
        return x;
    endfunction

    task automatic check(input string name, input rvec_t exp_r, input logic exp_v);
        int bad;
        bad = -1;
        nvec++;
        for (int k = 0; k < N; k++) begin
            if (bus.result[k] !== exp_r[k] && bad < 0) bad = k;
        end
        if (bus.valid !== exp_v) begin
            nmis++;
            $display("FAIL %s: valid got %b want %b", name, bus.valid, exp_v);
        end else if (bad >= 0) begin
            nmis++;
            $display("FAIL %s: result[%0d] got %h want %h", name, bad,
                     bus.result[bad], exp_r[bad]);
        end
    endtask

    vec_t  tbl [NTBL];
    rvec_t hist [NSTRM];
    rvec_t zero;

    initial begin
        zero = '0;
        for (int t = 0; t < NTBL; t++) begin
            tbl[t].c = '0;
            tbl[t].v = '0;
            tbl[t].r = '0;
        end
        // identity
        tbl[0].c[0] = 31'd1;
        for (int k = 0; k < N; k++) begin
            tbl[0].v[k] = W'(k);
            tbl[0].r[k] = W'(k);
        end
        // shift by one: r[i] = v[i+1]
        tbl[1].c[1] = 31'd1;
        for (int k = 0; k < N; k++) begin
            tbl[1].v[k] = W'(k);
            tbl[1].r[k] = W'((k + 1) % N);
        end
        // all p-1: (-1)*(-1)*16 = 16
        for (int k = 0; k < N; k++) begin
            tbl[2].c[k] = P - 1;
            tbl[2].v[k] = P - 1;
            tbl[2].r[k] = 31'd16;
        end
        // 2 * 2^30 = 2^31 = 1 mod p
        tbl[3].c[0] = 31'd2;
        tbl[3].v[0] = 31'h40000000;
        tbl[3].r[0] = 31'd1;
        // non-canonical vector input p behaves as 0
        tbl[4].c[0] = 31'd1;
        for (int k = 0; k < N; k++) tbl[4].v[k] = P;
        // both operands p
        for (int k = 0; k < N; k++) begin
            tbl[5].c[k] = P;
            tbl[5].v[k] = P;
        end
        // all-ones row: every r = 0+1+...+15 = 120
        for (int k = 0; k < N; k++) begin
            tbl[6].c[k] = 31'd1;
            tbl[6].v[k] = W'(k);
            tbl[6].r[k] = 31'd120;
        end
        // c[0]=3, c[15]=5, v[j]=j+1: r[i] = 3*v[i] + 5*v[i-1]
        tbl[7].c[0]  = 31'd3;
        tbl[7].c[15] = 31'd5;
        for (int k = 0; k < N; k++) begin
            tbl[7].v[k] = W'(k + 1);
            tbl[7].r[k] = (k == 0) ? 31'd83 : W'(8 * k + 3);
        end
        // 2*(p-1) = p-2
        tbl[8].c[0] = P - 1;
        tbl[8].c[1] = P - 1;
        for (int k = 0; k < N; k++) begin
            tbl[8].v[k] = 31'd1;
            tbl[8].r[k] = 31'h7FFFFFFD;
        end
        // 2^30 * 4 = 2^32 = 2 mod p
        tbl[9].c[0] = 31'h40000000;
        for (int k = 0; k < N; k++) begin
            tbl[9].v[k] = 31'd4;
            tbl[9].r[k] = 31'd2;
        end

        // Reset held two edges with arbitrary inputs
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            bus.mtx_row[k] = rnd_word();
            bus.vec[k]     = rnd_word();
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", zero, 1'b0);

        // Release. The first sample after reset must come out first.
        bus.mtx_row = tbl[0].c;
        bus.vec     = tbl[0].v;
        reset       = 1'b0;
        @(posedge clk); @(negedge clk);
        check("release_e1", zero, 1'b0);
        @(posedge clk); @(negedge clk);
        check("release_e2", zero, 1'b0);
        @(posedge clk); @(negedge clk);
        check("release_e3", tbl[0].r, 1'b1);

        // Directed table
        for (int t = 0; t < NTBL; t++) begin
            bus.mtx_row = tbl[t].c;
            bus.vec     = tbl[t].v;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check($sformatf("table%0d", t), tbl[t].r, 1'b1);
        end

        // Random stream with a one-cycle reset in the middle
        for (int t = 0; t < NSTRM; t++) begin
            @(negedge clk);
            if (t >= 3) begin
                if (t - 3 >= RST_T - 2 && t - 3 <= RST_T)
                    check($sformatf("stream_rst%0d", t), zero, 1'b0);
                else
                    check($sformatf("stream%0d", t), hist[t - 3], 1'b1);
            end
            reset = (t == RST_T);
            for (int k = 0; k < N; k++) begin
                bus.mtx_row[k] = rnd_word();
                bus.vec[k]     = rnd_word();
            end
            hist[t] = ref_mul(bus.mtx_row, bus.vec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
